calc_op_sequencer: RTL and testbench

//  Multi-cycle operation sequencer that sits directly upstream of full_adder_nbits.

---
 rtl/calc_op_sequencer.sv | 136 +++++++++++++
 tb/tb_calc_op_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// Multi-cycle ADD/SUB/MUL sequencer driving an external full_adder_nbits.
// SUB runs a two's-complement negate pass then an add pass; MUL is shift-add.
module calc_op_sequencer #(
  parameter int width = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [width-1:0]   a_i,
  input  logic [width-1:0]   b_i,
  output logic               ready_o,
  output logic [width-1:0]   add_a_o,
  output logic [width-1:0]   add_b_o,
  input  logic [width-1:0]   add_s_i,
  input  logic               add_cout_i,
  output logic [2*width-1:0] result_o,
  output logic               carry_o,
  output logic               err_o,
  output logic               done_o
);

  localparam int CW = $clog2(width) + 1;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEG,
    S_ADD,
    S_MUL,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [width-1:0]   a_q, b_q;
  logic [1:0]         op_q;
  logic               neg_c;
  logic [2*width-1:0] p_q, p_next;
  logic [CW-1:0]      cnt_q;
  logic               accept, last_mul;

  assign ready_o  = (state_q == S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign accept   = start_i & ready_o;
  assign last_mul = (cnt_q == CW'(width - 1));
  // Partial product shifts right one bit per pass, absorbing the adder carry at the top.
  assign p_next   = {add_cout_i, add_s_i, p_q[width-1:1]};

  always_comb begin
    state_d = state_q;
    add_a_o = '0;
    add_b_o = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_i)
            OP_ADD:  state_d = S_ADD;
            OP_SUB:  state_d = S_NEG;
            OP_MUL:  state_d = S_MUL;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_NEG: begin
        add_a_o = ~b_q;
        add_b_o = width'(1);
        state_d = S_ADD;
      end
      S_ADD: begin
        add_a_o = a_q;
        add_b_o = b_q;
        state_d = S_DONE;
      end
      S_MUL: begin
        add_a_o = p_q[2*width-1:width];
        add_b_o = p_q[0] ? a_q : '0;
        if (last_mul) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      neg_c    <= 1'b0;
      p_q      <= '0;
      cnt_q    <= '0;
      result_o <= '0;
      carry_o  <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q   <= a_i;
            b_q   <= b_i;
            op_q  <= op_i;
            neg_c <= 1'b0;
            p_q   <= {{width{1'b0}}, b_i};
            cnt_q <= '0;
            if (op_i == 2'b11) err_o <= 1'b1;
          end
        end
        S_NEG: begin
          b_q   <= add_s_i;
          neg_c <= add_cout_i;
        end
        S_ADD: begin
          result_o <= {{width{1'b0}}, add_s_i};
          // Negating zero is the only case that carries, and then a >= b always holds.
          carry_o  <= (op_q == OP_SUB) ? (add_cout_i | neg_c) : add_cout_i;
          err_o    <= 1'b0;
        end
        S_MUL: begin
          p_q   <= p_next;
          cnt_q <= cnt_q + CW'(1);
          if (last_mul) begin
            result_o <= p_next;
            carry_o  <= 1'b0;
            err_o    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Randomized self-checking bench for calc_op_sequencer with a behavioural
// adder and an arithmetic reference model of each operation.
module tb_calc_op_sequencer;

  localparam int W = 4;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           start_i;
  logic [1:0]     op_i;
  logic [W-1:0]   a_i, b_i;
  logic           ready_o;
  logic [W-1:0]   add_a_o, add_b_o, add_s_i;
  logic           add_cout_i;
  logic [2*W-1:0] result_o;
  logic           carry_o, err_o, done_o;

  int compared   = 0;
  int mismatched = 0;

  logic [2*W-1:0] exp_result = '0;
  logic           exp_carry  = 1'b0;
  logic           exp_err    = 1'b0;

  always #5 clk_i = ~clk_i;

  // Stand-in for the attached full_adder_nbits.
  assign {add_cout_i, add_s_i} = {1'b0, add_a_o} + {1'b0, add_b_o};

  calc_op_sequencer #(.width(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .ready_o(ready_o),
    .add_a_o(add_a_o), .add_b_o(add_b_o), .add_s_i(add_s_i), .add_cout_i(add_cout_i),
    .result_o(result_o), .carry_o(carry_o), .err_o(err_o), .done_o(done_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: result/carry/err/latency from plain arithmetic on the operands.
  task automatic modelOp(input logic [1:0] op, input int a, input int b, output int lat);
    case (op)
      2'b00: begin
        exp_result = 8'((a + b) % 16); exp_carry = (a + b) >= 16; exp_err = 0; lat = 2;
      end
      2'b01: begin
        exp_result = 8'((a - b + 16) % 16); exp_carry = a >= b; exp_err = 0; lat = 3;
      end
      2'b10: begin
        exp_result = 8'(a * b); exp_carry = 0; exp_err = 0; lat = W + 1;
      end
      default: begin
        exp_err = 1; lat = 1;
      end
    endcase
  endtask

  task automatic applyStimulus(input logic [1:0] op, input int a, input int b, input bit noise);
    int lat, n;
    modelOp(op, a, b, lat);
    @(negedge clk_i);
    checkOutput("ready_before_accept", 32'(ready_o), 1);
    start_i = 1'b1; op_i = op; a_i = W'(a); b_i = W'(b);
    @(negedge clk_i);
    n = 1;
    while (!done_o && n < 20) begin
      start_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      op_i = 2'($urandom); a_i = W'($urandom); b_i = W'($urandom);
      @(negedge clk_i);
      n++;
    end
    start_i = 1'b0;
    checkOutput("latency", 32'(n), 32'(lat));
    checkOutput("result", 32'(result_o), 32'(exp_result));
    checkOutput("carry", 32'(carry_o), 32'(exp_carry));
    checkOutput("err", 32'(err_o), 32'(exp_err));
    @(negedge clk_i);
    checkOutput("done_pulse_end", 32'(done_o), 0);
    checkOutput("result_held", 32'(result_o), 32'(exp_result));
  endtask

  initial begin
    int lat;
    rst_ni = 1'b0; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (2) @(negedge clk_i);
    checkOutput("rst_ready", 32'(ready_o), 1);
    checkOutput("rst_done", 32'(done_o), 0);
    checkOutput("rst_result", 32'(result_o), 0);
    checkOutput("rst_carry_err", 32'({carry_o, err_o}), 0);
    rst_ni = 1'b1;

    applyStimulus(2'b00, 9, 8, 1'b0);
    applyStimulus(2'b01, 5, 3, 1'b0);
    applyStimulus(2'b01, 3, 5, 1'b0);
    applyStimulus(2'b01, 7, 0, 1'b0);
    applyStimulus(2'b10, 15, 15, 1'b0);
    applyStimulus(2'b10, 0, 9, 1'b0);
    applyStimulus(2'b10, 6, 1, 1'b1);
    applyStimulus(2'b11, 4, 4, 1'b0);
    applyStimulus(2'b00, 1, 2, 1'b0);

    // Reset during the second MUL cycle aborts without a done pulse.
    modelOp(2'b10, 7, 5, lat);
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b10; a_i = 4'd7; b_i = 4'd5;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    exp_result = '0; exp_carry = 1'b0; exp_err = 1'b0;
    checkOutput("abort_ready", 32'(ready_o), 1);
    checkOutput("abort_result", 32'(result_o), 0);
    for (int i = 0; i < W + 2; i++) begin
      checkOutput("abort_no_done", 32'(done_o), 0);
      @(negedge clk_i);
    end

    for (int i = 0; i < 40; i++)
      applyStimulus(2'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
